// File: rtl/hdmi_period_scheduler_if.sv
// Video timing/pixel stream in, delayed stream plus HDMI period control out.
// The slave side is the scheduler; the master side is whoever drives the
// video timing and packet requests and consumes the period information.
interface hdmi_period_scheduler_if;
    // Upstream timing and pixels
    logic       de_in;
    logic       hsync_in;
    logic       vsync_in;
    logic [7:0] pixel_data_in_0;
    logic [7:0] pixel_data_in_1;
    logic [7:0] pixel_data_in_2;
    // Level request per packet source, bit i = source i
    logic [1:0] pkt_req;

    // Delayed timing and pixels
    logic       de_out;
    logic       hsync_out;
    logic       vsync_out;
    logic [7:0] pixel_data_out_0;
    logic [7:0] pixel_data_out_1;
    logic [7:0] pixel_data_out_2;
    // Period classification and transmitter control
    logic [2:0] period;
    logic [3:0] ctl;
    logic [1:0] pkt_grant;
    logic       pkt_rd;
    logic [4:0] pkt_idx;
    logic       err;

    modport master (
        output de_in, hsync_in, vsync_in,
        output pixel_data_in_0, pixel_data_in_1, pixel_data_in_2,
        output pkt_req,
        input  de_out, hsync_out, vsync_out,
        input  pixel_data_out_0, pixel_data_out_1, pixel_data_out_2,
        input  period, ctl, pkt_grant, pkt_rd, pkt_idx, err
    );

    modport slave (
        input  de_in, hsync_in, vsync_in,
        input  pixel_data_in_0, pixel_data_in_1, pixel_data_in_2,
        input  pkt_req,
        output de_out, hsync_out, vsync_out,
        output pixel_data_out_0, pixel_data_out_1, pixel_data_out_2,
        output period, ctl, pkt_grant, pkt_rd, pkt_idx, err
    );
endinterface

// File: rtl/hdmi_period_scheduler.sv
// HDMI period scheduler.
// Delays the video stream by LOOKAHEAD cycles so that the de of the coming
// cycles is known in advance. That window drives the video preamble/guard
// band classification; between video periods a data-island FSM launches one
// packet island per line on the hsync leading edge, arbitrating round-robin
// between two packet sources.
//
// Timing convention: an output presented after clock edge t equals the input
// captured at edge t-LOOKAHEAD. The line therefore has LOOKAHEAD+1 stages:
// stage 0 captures the input and stage LOOKAHEAD drives the outputs. That
// gives the registered period/ctl logic the full lookahead window D(1..L),
// where D(L) is the input being captured at the same edge.
module hdmi_period_scheduler #(
    parameter int LOOKAHEAD    = 10,
    parameter bit HSYNC_ACTIVE = 1'b1
) (
    input logic                    pixel_clk,
    input logic                    rst,
    hdmi_period_scheduler_if.slave bus
);

    typedef enum logic [2:0] {
        P_CTRL     = 3'd0,
        P_VID_PRE  = 3'd1,
        P_VID_GB   = 3'd2,
        P_VIDEO    = 3'd3,
        P_ISL_PRE  = 3'd4,
        P_ISL_GB   = 3'd5,
        P_ISL_DATA = 3'd6
    } period_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_GB_LEAD,
        S_DATA,
        S_GB_TRAIL
    } state_e;

    typedef struct packed {
        logic       de;
        logic       hs;
        logic       vs;
        logic [7:0] p0;
        logic [7:0] p1;
        logic [7:0] p2;
    } word_t;

    // Last cycle index of each island phase (counter counts from 0)
    localparam logic [4:0] PRE_LAST  = 5'd7;
    localparam logic [4:0] GB_LAST   = 5'd1;
    localparam logic [4:0] DATA_LAST = 5'd31;

    localparam logic [3:0] CTL_VID_PRE = 4'b0001;
    localparam logic [3:0] CTL_ISL_PRE = 4'b0101;
    localparam logic [3:0] CTL_NONE    = 4'b0000;

    word_t              dl  [0:LOOKAHEAD];   // registered delay line
    word_t              nxt [0:LOOKAHEAD];   // delay line contents after this edge
    logic [LOOKAHEAD:0] de_nxt;              // de_nxt[LOOKAHEAD-k] = D(k) of the next cycle

    state_e     st;
    logic [4:0] cnt;
    logic       prio;                        // source that wins when both request

    period_e    period_q;
    logic [3:0] ctl_q;
    logic [1:0] grant_q;
    logic       rd_q;
    logic [4:0] idx_q;
    logic       err_q;

    logic vid_n;
    logic gb_n;
    logic pre_n;
    logic any_vid_n;
    logic short_gap_n;
    logic hs_edge_n;
    logic fsm_free;
    logic win;

    // Contents of the delay line as they will be after the coming edge
    always_comb begin
        nxt[0].de = bus.de_in;
        nxt[0].hs = bus.hsync_in;
        nxt[0].vs = bus.vsync_in;
        nxt[0].p0 = bus.pixel_data_in_0;
        nxt[0].p1 = bus.pixel_data_in_1;
        nxt[0].p2 = bus.pixel_data_in_2;
        for (int j = 1; j <= LOOKAHEAD; j++) begin
            nxt[j] = dl[j-1];
        end
        for (int j = 0; j <= LOOKAHEAD; j++) begin
            de_nxt[j] = nxt[j].de;
        end
    end

    // Classification of the next output cycle from the lookahead window
    always_comb begin
        vid_n     = de_nxt[LOOKAHEAD];
        gb_n      = !vid_n && (de_nxt[LOOKAHEAD-1] || de_nxt[LOOKAHEAD-2]);
        pre_n     = !vid_n && !gb_n && (|de_nxt[LOOKAHEAD-3:0]);
        any_vid_n = vid_n || gb_n || pre_n;
        // de_out falls and the next active line starts before a full
        // preamble plus guard band could be sent
        short_gap_n = dl[LOOKAHEAD].de && !vid_n && (|de_nxt[LOOKAHEAD-1:1]);
        hs_edge_n   = (nxt[LOOKAHEAD].hs == HSYNC_ACTIVE) &&
                      (dl[LOOKAHEAD].hs != HSYNC_ACTIVE);
        // The FSM is free next cycle if idle now or finishing the trailing guard band
        fsm_free    = (st == S_IDLE) || (st == S_GB_TRAIL && cnt == GB_LAST);
        // Both requesting: the priority holder wins; otherwise the lone requester
        win         = (bus.pkt_req == 2'b11) ? prio : bus.pkt_req[1];
    end

    // Delay line, island FSM and all registered outputs
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            for (int j = 0; j <= LOOKAHEAD; j++) begin
                dl[j] <= '0;
            end
            st       <= S_IDLE;
            cnt      <= '0;
            prio     <= 1'b0;
            period_q <= P_CTRL;
            ctl_q    <= CTL_NONE;
            grant_q  <= 2'b00;
            rd_q     <= 1'b0;
            idx_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            for (int j = 0; j <= LOOKAHEAD; j++) begin
                dl[j] <= nxt[j];
            end
            grant_q <= 2'b00;
            rd_q    <= 1'b0;
            idx_q   <= '0;
            ctl_q   <= CTL_NONE;

            if (any_vid_n) begin
                // Video timing always wins; an island still running is cut off
                if (!fsm_free) begin
                    err_q <= 1'b1;
                end
                st  <= S_IDLE;
                cnt <= '0;
                if (vid_n) begin
                    period_q <= P_VIDEO;
                end else if (gb_n) begin
                    period_q <= P_VID_GB;
                end else begin
                    period_q <= P_VID_PRE;
                    ctl_q    <= CTL_VID_PRE;
                end
            end else if (fsm_free) begin
                if (hs_edge_n && (bus.pkt_req != 2'b00)) begin
                    st       <= S_PRE;
                    cnt      <= '0;
                    grant_q  <= win ? 2'b10 : 2'b01;
                    prio     <= !win;
                    period_q <= P_ISL_PRE;
                    ctl_q    <= CTL_ISL_PRE;
                end else begin
                    st       <= S_IDLE;
                    cnt      <= '0;
                    period_q <= P_CTRL;
                end
            end else begin
                unique case (st)
                    S_PRE: begin
                        if (cnt == PRE_LAST) begin
                            st       <= S_GB_LEAD;
                            cnt      <= '0;
                            period_q <= P_ISL_GB;
                        end else begin
                            cnt      <= cnt + 5'd1;
                            period_q <= P_ISL_PRE;
                            ctl_q    <= CTL_ISL_PRE;
                        end
                    end
                    S_GB_LEAD: begin
                        if (cnt == GB_LAST) begin
                            st       <= S_DATA;
                            cnt      <= '0;
                            period_q <= P_ISL_DATA;
                            rd_q     <= 1'b1;
                        end else begin
                            cnt      <= cnt + 5'd1;
                            period_q <= P_ISL_GB;
                        end
                    end
                    S_DATA: begin
                        if (cnt == DATA_LAST) begin
                            st       <= S_GB_TRAIL;
                            cnt      <= '0;
                            period_q <= P_ISL_GB;
                        end else begin
                            cnt      <= cnt + 5'd1;
                            period_q <= P_ISL_DATA;
                            rd_q     <= 1'b1;
                            idx_q    <= cnt + 5'd1;
                        end
                    end
                    S_GB_TRAIL: begin
                        // Last trail cycle is handled by the fsm_free branch
                        cnt      <= cnt + 5'd1;
                        period_q <= P_ISL_GB;
                    end
                    default: begin
                        st       <= S_IDLE;
                        cnt      <= '0;
                        period_q <= P_CTRL;
                    end
                endcase
            end

            if (short_gap_n) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.de_out           = dl[LOOKAHEAD].de;
    assign bus.hsync_out        = dl[LOOKAHEAD].hs;
    assign bus.vsync_out        = dl[LOOKAHEAD].vs;
    assign bus.pixel_data_out_0 = dl[LOOKAHEAD].p0;
    assign bus.pixel_data_out_1 = dl[LOOKAHEAD].p1;
    assign bus.pixel_data_out_2 = dl[LOOKAHEAD].p2;
    assign bus.period           = period_q;
    assign bus.ctl              = ctl_q;
    assign bus.pkt_grant        = grant_q;
    assign bus.pkt_rd           = rd_q;
    assign bus.pkt_idx          = idx_q;
    assign bus.err              = err_q;

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// Scoreboard bench for hdmi_period_scheduler. Every stimulus cycle feeds a
// line-level reference model that pushes the expected output word for that
// cycle; a monitor pops and compares once per cycle on the falling edge.
module tb_hdmi_period_scheduler;
    localparam int L = 10;

    typedef struct packed {
        logic       de;
        logic       hs;
        logic       vs;
        logic [7:0] p0;
        logic [7:0] p1;
        logic [7:0] p2;
    } in_t;

    typedef struct packed {
        logic       de;
        logic       hs;
        logic       vs;
        logic [7:0] p0;
        logic [7:0] p1;
        logic [7:0] p2;
        logic [2:0] period;
        logic [3:0] ctl;
        logic [1:0] grant;
        logic       rd;
        logic [4:0] idx;
        logic       err;
    } exp_t;

    logic pixel_clk = 1'b0;
    logic rst;

    hdmi_period_scheduler_if bus();

    hdmi_period_scheduler #(
        .LOOKAHEAD   (L),
        .HSYNC_ACTIVE(1'b1)
    ) dut (
        .pixel_clk(pixel_clk),
        .rst      (rst),
        .bus      (bus)
    );

    always #5 pixel_clk = ~pixel_clk;

    // ---------------- reference model state ----------------
    in_t  hist[$];           // every captured input word, index = clock edge
    int   last_rst  = -1;    // last edge with rst high; older samples are flushed
    int   isl_start = -1;    // output cycle of the current island's first preamble
    bit   last_src  = 1'b1;  // source granted last (1 after reset => source 0 first)
    bit   err_m     = 1'b0;
    exp_t prev_o    = '0;
    exp_t expq[$];

    int checks = 0;
    int passed = 0;
    int mon_cyc = 0;
    int drain_bad = 0;

    function automatic in_t get(input int m);
        in_t z;
        z = '0;
        if (m >= 0 && m > last_rst && m < hist.size()) z = hist[m];
        return z;
    endfunction

    // Expected outputs of the cycle following the edge that captures w
    task automatic model_step(input in_t w, input logic [1:0] req, input bit r);
        exp_t       e;
        in_t        o;
        in_t        t;
        logic [L:1] d;
        bit         vid, gb, pre, hs_edge, busy;
        int         ph, n;
        n = hist.size();
        hist.push_back(w);
        e = '0;
        if (r) begin
            last_rst  = n;
            isl_start = -1;
            last_src  = 1'b1;
            err_m     = 1'b0;
        end else begin
            o = get(n - L);
            e.de = o.de; e.hs = o.hs; e.vs = o.vs;
            e.p0 = o.p0; e.p1 = o.p1; e.p2 = o.p2;
            for (int k = 1; k <= L; k++) begin
                t = get(n - L + k);
                d[k] = t.de;
            end
            vid  = o.de;
            gb   = !vid && (d[1] || d[2]);
            pre  = !vid && !gb && (d[L:3] != '0);
            busy = (isl_start >= 0) && (n - isl_start < 44);
            if (prev_o.de && !vid && (d[L-1:1] != '0)) err_m = 1'b1;
            hs_edge = o.hs && !prev_o.hs;
            if (vid || gb || pre) begin
                if (busy) err_m = 1'b1;
                isl_start = -1;
                e.period  = vid ? 3'd3 : (gb ? 3'd2 : 3'd1);
                e.ctl     = pre ? 4'b0001 : 4'b0000;
            end else begin
                if (!busy && hs_edge && req != 2'b00) begin
                    if (req == 2'b11) last_src = !last_src;
                    else              last_src = req[1];
                    isl_start = n;
                end
                if (isl_start >= 0 && n - isl_start < 44) begin
                    ph = n - isl_start;
                    if (ph < 8) begin
                        e.period = 3'd4;
                        e.ctl    = 4'b0101;
                        if (ph == 0) e.grant = last_src ? 2'b10 : 2'b01;
                    end else if (ph < 10) begin
                        e.period = 3'd5;
                    end else if (ph < 42) begin
                        e.period = 3'd6;
                        e.rd     = 1'b1;
                        e.idx    = 5'(ph - 10);
                    end else begin
                        e.period = 3'd5;
                    end
                end
            end
            e.err = err_m;
        end
        prev_o = e;
        expq.push_back(e);
    endtask

    // One clock of stimulus: drive, predict, advance to the next falling edge
    task automatic step(input bit de, input bit hs, input logic [1:0] req, input bit r);
        in_t w;
        w.de = de;
        w.hs = hs;
        w.vs = 1'($urandom_range(0, 1));
        w.p0 = 8'($urandom);
        w.p1 = 8'($urandom);
        w.p2 = 8'($urandom);
        rst                 = r;
        bus.de_in           = w.de;
        bus.hsync_in        = w.hs;
        bus.vsync_in        = w.vs;
        bus.pixel_data_in_0 = w.p0;
        bus.pixel_data_in_1 = w.p1;
        bus.pixel_data_in_2 = w.p2;
        bus.pkt_req         = req;
        model_step(w, req, r);
        @(negedge pixel_clk);
    endtask

    task automatic run(input int cyc, input bit de, input bit hs, input logic [1:0] req, input bit r);
        for (int i = 0; i < cyc; i++) step(de, hs, req, r);
    endtask

    // Monitor: one expected word per output cycle
    always @(negedge pixel_clk) begin
        exp_t e;
        exp_t a;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            a = {bus.de_out, bus.hsync_out, bus.vsync_out,
                 bus.pixel_data_out_0, bus.pixel_data_out_1, bus.pixel_data_out_2,
                 bus.period, bus.ctl, bus.pkt_grant, bus.pkt_rd, bus.pkt_idx, bus.err};
            checks++;
            if (a === e) begin
                passed++;
            end else begin
                $display("FAIL cycle %0d outputs: got %h (period %0d ctl %b grant %b rd %b idx %0d err %b) expected %h (period %0d ctl %b grant %b rd %b idx %0d err %b)",
                         mon_cyc, a, a.period, a.ctl, a.grant, a.rd, a.idx, a.err,
                         e, e.period, e.ctl, e.grant, e.rd, e.idx, e.err);
            end
            mon_cyc++;
        end
    end

    initial begin
        int  len;
        bit  r;
        rst = 1'b1;
        bus.de_in = 1'b0; bus.hsync_in = 1'b0; bus.vsync_in = 1'b0;
        bus.pixel_data_in_0 = '0; bus.pixel_data_in_1 = '0; bus.pixel_data_in_2 = '0;
        bus.pkt_req = 2'b00;

        run(3, 0, 0, 2'b00, 1);

        // Video line after reset: preamble, guard band, active
        run(20, 0, 0, 2'b00, 0);
        run(40, 1, 0, 2'b00, 0);
        run(30, 0, 0, 2'b00, 0);

        // Three islands with both sources requesting
        for (int i = 0; i < 3; i++) begin
            run(4, 0, 1, 2'b11, 0);
            run(60, 0, 0, 2'b11, 0);
        end

        // hsync edge with no request
        run(4, 0, 1, 2'b00, 0);
        run(60, 0, 0, 2'b00, 0);

        // Island cut short by a video preamble in its data phase
        run(4, 0, 1, 2'b01, 0);
        run(26, 0, 0, 2'b01, 0);
        run(30, 1, 0, 2'b01, 0);
        run(30, 0, 0, 2'b00, 0);

        // Short blanking gap between two active periods
        run(20, 1, 0, 2'b00, 0);
        run(4, 0, 0, 2'b00, 0);
        run(20, 1, 0, 2'b00, 0);
        run(30, 0, 0, 2'b00, 0);

        // Reset mid data island, then both request: source 0 must win
        run(4, 0, 1, 2'b01, 0);
        run(32, 0, 0, 2'b01, 0);
        run(1, 0, 0, 2'b01, 1);
        run(5, 0, 0, 2'b00, 0);
        run(4, 0, 1, 2'b11, 0);
        run(60, 0, 0, 2'b10, 0);

        // Random segments
        for (int s = 0; s < 60; s++) begin
            r   = ($urandom_range(0, 25) == 0);
            len = r ? 2 : int'($urandom_range(1, 45));
            run(len, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                2'($urandom_range(0, 3)), r);
        end

        run(L + 5, 0, 0, 2'b00, 0);
        for (int i = 0; i < 20 && expq.size() > 0; i++) @(negedge pixel_clk);
        if (expq.size() != 0) begin
            drain_bad = 1;
            $display("FAIL drain: %0d expected cycles left unchecked, required 0", expq.size());
        end
        $display("%0d/%0d checks passed", passed, checks + drain_bad);
        $finish;
    end
endmodule
